multi_cycle_multiplier: RTL and testbench

Iterative shift-add multiplier that executes LEGv8 MUL, SMULH and UMULH.
- Sits directly downstream of the register file: takes BusA/BusB as operands and returns a 64-bit result for the write-back mux feeding BusW.
- Asserts Busy so the control unit can stall the PC and hold RegWr low until Done.
- Done marks the one cycle in which the result is written back on the register file's negedge write.

---
 rtl/multi_cycle_multiplier_pkg.sv | 39 +++
 rtl/multi_cycle_multiplier_twos_negate.sv | 12 +
 rtl/multi_cycle_multiplier.sv | 128 ++++++++++++
 tb/tb_multi_cycle_multiplier.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_multiplier_pkg.sv
// Shared definitions for the iterative LEGv8 multiplier: state encoding,
// default operand width and the opcode to (Signed, HighSel) decode.
package multi_cycle_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_SMULH = 2'd1,
        OP_UMULH = 2'd2
    } mul_op_t;

    typedef struct packed {
        logic is_signed;
        logic high_sel;
    } mul_ctrl_t;

    // MUL returns the low half; its low half is the same for signed and
    // unsigned operands, so it is issued as signed.
    function automatic mul_ctrl_t decode_mul_op(input mul_op_t op);
        mul_ctrl_t ctrl;
        ctrl = '{is_signed: 1'b1, high_sel: 1'b0};
        case (op)
            OP_MUL:   ctrl = '{is_signed: 1'b1, high_sel: 1'b0};
            OP_SMULH: ctrl = '{is_signed: 1'b1, high_sel: 1'b1};
            OP_UMULH: ctrl = '{is_signed: 1'b0, high_sel: 1'b1};
            default:  ctrl = '{is_signed: 1'b1, high_sel: 1'b0};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/multi_cycle_multiplier_twos_negate.sv
// Two's-complement negation (~x + 1) at an arbitrary width, wrapping modulo
// 2^WIDTH. The most negative value maps onto itself.
module twos_negate #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] negated
);

    assign negated = ~value + WIDTH'(1);

endmodule

// File: rtl/multi_cycle_multiplier.sv
// Iterative shift-add multiplier for LEGv8 MUL / SMULH / UMULH.
// Signed operands are reduced to magnitudes, multiplied unsigned over WIDTH
// cycles and the sign is restored on the full 2*WIDTH product in FIX.
//
// state | meaning
// IDLE  | waiting for Start
// CALC  | one shift-add iteration per cycle, WIDTH iterations
// FIX   | apply sign to product, select half into Result
// DONE  | Done pulse; Start here chains the next operation
module multi_cycle_multiplier
    import multi_cycle_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic             HighSel,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t state_q, state_d;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      count_q;
    logic               neg_q;
    logic               high_q;

    logic [WIDTH-1:0]   neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_neg;
    logic [2*WIDTH-1:0] product;
    logic               start_ok;

    twos_negate #(.WIDTH(WIDTH)) u_neg_a (
        .value   (BusA),
        .negated (neg_a)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_b (
        .value   (BusB),
        .negated (neg_b)
    );

    twos_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .value   (acc_q),
        .negated (acc_neg)
    );

    assign mag_a    = (Signed && BusA[WIDTH-1]) ? neg_a : BusA;
    assign mag_b    = (Signed && BusB[WIDTH-1]) ? neg_b : BusB;
    assign product  = neg_q ? acc_neg : acc_q;
    assign start_ok = Start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state decode; Start is only honoured in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = CALC;
            CALC:    if (count_q == LAST_COUNT) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = Start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture and shift-add datapath. The multiplicand is kept
    // pre-shifted in a 2*WIDTH register so each iteration is a plain add.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            high_q   <= 1'b0;
        end else if (start_ok) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= Signed & (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
            high_q   <= HighSel;
        end else if (state_q == CALC) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CW'(1);
        end
    end

    // Registered outputs; Result only changes in FIX and holds otherwise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Result <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            if (state_q == FIX) begin
                Result <= high_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
            end
            Busy <= (state_d == CALC) || (state_d == FIX);
            Done <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_multi_cycle_multiplier.sv
// Self-checking bench for multi_cycle_multiplier: directed corner cases plus
// randomized operations against a full-width arithmetic reference.
module tb_multi_cycle_multiplier;
    import multi_cycle_multiplier_pkg::*;

    localparam int W = 64;
    localparam int LATENCY = W + 1;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Signed;
    logic         HighSel;
    logic [W-1:0] BusA;
    logic [W-1:0] BusB;
    logic [W-1:0] Result;
    logic         Busy;
    logic         Done;

    int errors = 0;
    int checks = 0;

    multi_cycle_multiplier #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Signed  (Signed),
        .HighSel (HighSel),
        .BusA    (BusA),
        .BusB    (BusB),
        .Result  (Result),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: extend operands to 2W per signedness, multiply, pick half.
    function automatic logic [W-1:0] ref_mul(input bit s, input bit h,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb, p;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        p  = ea * eb;
        return h ? p[2*W-1:W] : p[W-1:0];
    endfunction

    // Present an operation at the negedge and return #1 after the sampling edge.
    task automatic issue(input bit s, input bit h, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold);
        @(negedge Clk);
        Start = 1'b1; Signed = s; HighSel = h; BusA = a; BusB = b;
        @(posedge Clk);
        #1;
        check_eq("busy_at_start", W'(Busy), W'(1));
        if (!hold) Start = 1'b0;
    endtask

    // Count edges until Done is seen; edges = -1 on timeout.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = -1;
        busy_cycles = 1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge Clk);
            #1;
            if (Busy) busy_cycles++;
            if (Done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input bit s, input bit h,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        int edges, busy_cycles;
        issue(s, h, a, b, 1'b0);
        wait_done(edges, busy_cycles);
        check_eq({tag, "_latency"}, W'(edges), W'(LATENCY));
        check_eq({tag, "_busy_cycles"}, W'(busy_cycles), W'(LATENCY));
        check_eq({tag, "_result"}, Result, ref_mul(s, h, a, b));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 64'h8000_0000_0000_0000;
            1:       return '1;
            2:       return W'($urandom_range(0, 20));
            3:       return -W'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        mul_ctrl_t c_mul, c_smulh, c_umulh;
        int edges, busy_cycles, done_seen;
        logic [W-1:0] a, b, a2, b2, exp_hold;
        bit s, h;

        c_mul   = decode_mul_op(OP_MUL);
        c_smulh = decode_mul_op(OP_SMULH);
        c_umulh = decode_mul_op(OP_UMULH);

        Reset = 1'b1; Start = 1'b0; Signed = 1'b0; HighSel = 1'b0; BusA = '0; BusB = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("reset_result", Result, '0);
        check_eq("reset_busy", W'(Busy), '0);
        check_eq("reset_done", W'(Done), '0);
        @(negedge Clk);
        Reset = 1'b0;

        run_op("mul_3x5", c_mul.is_signed, c_mul.high_sel, 64'd3, 64'd5);
        @(posedge Clk); #1;
        check_eq("done_one_cycle", W'(Done), '0);
        repeat (4) @(posedge Clk);
        #1;
        check_eq("result_hold", Result, 64'd15);

        run_op("umulh_ff", c_umulh.is_signed, c_umulh.high_sel, '1, '1);
        run_op("umul_lo_ff", 1'b0, 1'b0, '1, '1);
        run_op("smulh_m1x1", c_smulh.is_signed, c_smulh.high_sel, '1, 64'd1);
        run_op("mul_m1x1", c_mul.is_signed, c_mul.high_sel, '1, 64'd1);
        run_op("corner_lo", 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_op("corner_hi", 1'b1, 1'b1, 64'h8000_0000_0000_0000, '1);

        // Start pulsed in CALC must be ignored.
        issue(1'b1, 1'b0, 64'd1234, 64'd77, 1'b0);
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b1; BusA = 64'd999; BusB = 64'd5; HighSel = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(edges, busy_cycles);
        check_eq("ignore_latency", W'(edges), W'(LATENCY - 11));
        check_eq("ignore_result", Result, 64'd95018);
        @(posedge Clk); #1;
        check_eq("ignore_no_restart", W'(Busy), '0);

        // Back-to-back: Start held through the Done cycle.
        a = 64'hFFFF_FFFF_FFFF_FFF9; b = 64'd6;
        a2 = 64'd7; b2 = 64'd9;
        issue(1'b1, 1'b0, a, b, 1'b1);
        wait_done(edges, busy_cycles);
        check_eq("b2b_first_latency", W'(edges), W'(LATENCY));
        check_eq("b2b_first_result", Result, ref_mul(1'b1, 1'b0, a, b));
        Signed = 1'b0; HighSel = 1'b0; BusA = a2; BusB = b2;
        @(posedge Clk); #1;
        check_eq("b2b_busy_again", W'(Busy), W'(1));
        check_eq("b2b_done_low", W'(Done), '0);
        Start = 1'b0;
        wait_done(edges, busy_cycles);
        check_eq("b2b_second_latency", W'(edges), W'(LATENCY));
        check_eq("b2b_second_result", Result, 64'd63);

        // Reset in the middle of CALC discards the operation.
        issue(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0);
        repeat (30) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_eq("rst_busy", W'(Busy), '0);
        check_eq("rst_done", W'(Done), '0);
        check_eq("rst_result", Result, '0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge Clk); #1;
            if (Done || Busy) done_seen++;
        end
        check_eq("rst_no_done", W'(done_seen), '0);
        run_op("after_rst", 1'b1, 1'b0, 64'd11, -64'd13);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            a = pick_operand();
            b = pick_operand();
            run_op($sformatf("rand%0d", i), s, h, a, b);
            if ($urandom_range(0, 1) == 1) begin
                exp_hold = ref_mul(s, h, a, b);
                repeat (3) @(posedge Clk);
                #1;
                check_eq($sformatf("rand%0d_hold", i), Result, exp_hold);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
